manual_setting_seq: RTL
=======================

MANUAL_SETTING_SEQ -- requirements
Module: manual_setting_seq

Interface
REQ-001 Parameter NUM_FIELDS, default 3, number of settable fields (field 0 = hour, 1 = minute, 2 = second).
REQ-002 Parameter FIELD_W, default 6, bit width of each field value.
REQ-003 Parameter TIMEOUT_CYC, default 1000, idle cycles before auto-abort (used only with the timeout feature).
REQ-004 Ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; rising edge enters setting mode.
- sharp  in  1  level; rising edge confirms current field and advances.
- star  in  1  level; rising edge steps back one field.
- up  in  1  level; rising edge increments current field.
- down  in  1  level; rising edge decrements current field.
- load_vals  in  NUM_FIELDS*FIELD_W  current time, field i at bits [i*FIELD_W +: FIELD_W].
- field_en  out  NUM_FIELDS  one-hot enable of field being edited.
- set_vals  out  NUM_FIELDS*FIELD_W  edited values, same packing as load_vals.
- busy  out  1  high while in EDIT.
- completeSetting  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse on abort.

Function
REQ-005 Every key input SHALL be edge-detected internally, and only a 0->1 transition SHALL count as one press.
REQ-006 States SHALL be IDLE, EDIT and DONE.
REQ-007 IDLE: on a start edge, the block SHALL copy load_vals into set_vals, set field index 0, and enter EDIT next cycle.
REQ-008 EDIT: field_en SHALL be one-hot at the current index and busy SHALL be 1; in IDLE and DONE, field_en = 0 and busy = 0.
REQ-009 EDIT, sharp edge: if index < NUM_FIELDS-1, the index SHALL advance by 1; at the last field the block SHALL enter DONE.
REQ-010 EDIT, star edge: if index > 0, the index SHALL go back by 1; at index 0 the block SHALL pulse aborted, enter IDLE, and restore set_vals to the values captured at start.
REQ-011 EDIT, up edge: the field SHALL increment, wrapping from its limit to 0.
REQ-012 EDIT, down edge: the field SHALL decrement, wrapping from 0 to its limit.
REQ-013 Field limits SHALL be 23 for field 0 and 59 for all other fields; arithmetic SHALL stay within FIELD_W bits.
REQ-014 Simultaneous key edges in one cycle: only the highest-priority key SHALL act, with priority star > sharp > up > down; all others SHALL be discarded.
REQ-015 DONE: completeSetting SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; set_vals SHALL hold until the next start.
REQ-016 start edges while in EDIT or DONE SHALL be ignored.
REQ-017 Key edges arriving in IDLE (other than start) SHALL have no effect.

Reset
REQ-018 With reset low at a clock edge, the block SHALL go to state IDLE, index 0, set_vals = 0, field_en = 0, busy = 0, completeSetting = 0, aborted = 0, and clear the edge-detect history.
REQ-019 Reset during EDIT SHALL discard edits with no completeSetting or aborted pulse.
REQ-020 A key held high across reset release SHALL NOT register as a press.

Configuration
REQ-021 With macro MANUAL_SETTING_TIMEOUT_EN defined, a counter SHALL clear on every accepted key edge in EDIT; at TIMEOUT_CYC consecutive idle EDIT cycles, the block SHALL behave exactly as a star-abort from field 0 (REQ-010).
REQ-022 Without MANUAL_SETTING_TIMEOUT_EN, no timeout counter SHALL exist and EDIT SHALL persist indefinitely.

Structure
REQ-023 A shared package SHALL hold the state enum, the key priority encoding, and the field limit constants (HOUR_MAX = 23, MINSEC_MAX = 59).
REQ-024 A sub-module key_edge (per-key rising-edge detector, width-parametrised) SHALL be instantiated once for all five keys.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset, start with load_vals = {59,30,12} -> field_en = 001 next cycle; sharp×3 -> completeSetting pulses once and set_vals = {59,30,12}.
- Field 0 = 23, up -> 0; then down -> 23; field 1 = 0, down -> 59.
- Field 1 edited to 45, then star, then star -> field_en 010 -> 001 -> aborted pulse and set_vals restored to start values.
- sharp and up edges in the same cycle -> index advances and the value is unchanged; up held high for 10 cycles -> single increment.
- Reset low mid-EDIT -> next cycle all outputs 0, with no pulse.
- With MANUAL_SETTING_TIMEOUT_EN and TIMEOUT_CYC = 16: start, then no keys for 16 cycles -> aborted pulse and busy = 0.

Source files
------------

// File: rtl/manual_setting_seq_pkg.sv
// Shared types and constants for the manual time-setting sequencer:
// FSM states, key priority encoding and field limits.
package manual_setting_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_STAR  = 3'd1,
    KEY_SHARP = 3'd2,
    KEY_UP    = 3'd3,
    KEY_DOWN  = 3'd4
  } key_e;

  // Bit positions of the keys inside the edge-detector vector
  localparam int KEY_NUM  = 5;
  localparam int KI_START = 0;
  localparam int KI_STAR  = 1;
  localparam int KI_SHARP = 2;
  localparam int KI_UP    = 3;
  localparam int KI_DOWN  = 4;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  function automatic key_e key_prio(input logic star, input logic sharp,
                                    input logic up, input logic down);
    if (star) begin
      return KEY_STAR;
    end else if (sharp) begin
      return KEY_SHARP;
    end else if (up) begin
      return KEY_UP;
    end else if (down) begin
      return KEY_DOWN;
    end else begin
      return KEY_NONE;
    end
  endfunction

endpackage

// File: rtl/manual_setting_seq_key_edge.sv
// Per-key rising-edge detector; one instance covers every key of the block.
module key_edge #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_r;

  // History preloads to all-ones so a key held through reset release is not a press
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_r <= {WIDTH{1'b1}};
    end else begin
      prev_r <= keys;
    end
  end

  assign rise = keys & ~prev_r;

endmodule

// File: rtl/manual_setting_seq.sv
// Key-driven hour/minute/second editor (IDLE -> EDIT -> DONE).
// Define MANUAL_SETTING_TIMEOUT_EN to auto-abort after TIMEOUT_CYC idle EDIT cycles.
module manual_setting_seq
  import manual_setting_seq_pkg::*;
#(
  parameter int NUM_FIELDS  = 3,
  parameter int FIELD_W     = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sharp,
  input  logic                          star,
  input  logic                          up,
  input  logic                          down,
  input  logic [NUM_FIELDS*FIELD_W-1:0] load_vals,
  output logic [NUM_FIELDS-1:0]         field_en,
  output logic [NUM_FIELDS*FIELD_W-1:0] set_vals,
  output logic                          busy,
  output logic                          completeSetting,
  output logic                          aborted
);

  localparam int IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int VALS_W = NUM_FIELDS * FIELD_W;

  logic [KEY_NUM-1:0]    keys_s;
  logic [KEY_NUM-1:0]    rise_s;
  key_e                  key_s;
  logic [FIELD_W-1:0]    cur_s;
  logic [FIELD_W-1:0]    lim_s;
  logic [FIELD_W-1:0]    inc_s;
  logic [FIELD_W-1:0]    dec_s;
  logic                  tmo_hit_s;
  logic                  abort_s;

  state_e                state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [VALS_W-1:0]     vals_r;
  logic [VALS_W-1:0]     cap_r;
  logic [NUM_FIELDS-1:0] field_en_r;
  logic                  busy_r;
  logic                  complete_r;
  logic                  aborted_r;

  assign keys_s[KI_START] = start;
  assign keys_s[KI_STAR]  = star;
  assign keys_s[KI_SHARP] = sharp;
  assign keys_s[KI_UP]    = up;
  assign keys_s[KI_DOWN]  = down;

  key_edge #(
    .WIDTH (KEY_NUM)
  ) u_key_edge (
    .clock (clock),
    .reset (reset),
    .keys  (keys_s),
    .rise  (rise_s)
  );

  // Key arbitration and wrap-around arithmetic on the field being edited
  always_comb begin
    key_s = key_prio(rise_s[KI_STAR], rise_s[KI_SHARP], rise_s[KI_UP], rise_s[KI_DOWN]);
    cur_s = vals_r[int'(idx_r)*FIELD_W +: FIELD_W];
    if (idx_r == IDX_W'(0)) begin
      lim_s = FIELD_W'(HOUR_MAX);
    end else begin
      lim_s = FIELD_W'(MINSEC_MAX);
    end
    if (cur_s >= lim_s) begin
      inc_s = FIELD_W'(0);
    end else begin
      inc_s = cur_s + FIELD_W'(1);
    end
    if (cur_s == FIELD_W'(0)) begin
      dec_s = lim_s;
    end else begin
      dec_s = cur_s - FIELD_W'(1);
    end
    abort_s = ((key_s == KEY_STAR) && (idx_r == IDX_W'(0))) || tmo_hit_s;
  end

`ifdef MANUAL_SETTING_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_r;

  assign tmo_hit_s = (state_r == ST_EDIT) && (key_s == KEY_NONE) &&
                     (tmo_r == TMO_W'(TIMEOUT_CYC - 1));

  // Consecutive idle EDIT cycles; any accepted key restarts the count
  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_r <= TMO_W'(0);
    end else if ((state_r == ST_EDIT) && (key_s == KEY_NONE) && !tmo_hit_s) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= TMO_W'(0);
    end
  end
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYC > 0);
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_W'(0);
      vals_r     <= VALS_W'(0);
      cap_r      <= VALS_W'(0);
      field_en_r <= NUM_FIELDS'(0);
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      complete_r <= 1'b0;
      aborted_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s[KI_START]) begin
            vals_r     <= load_vals;
            cap_r      <= load_vals;
            idx_r      <= IDX_W'(0);
            field_en_r <= NUM_FIELDS'(1);
            busy_r     <= 1'b1;
            state_r    <= ST_EDIT;
          end
        end
        ST_EDIT: begin
          if (abort_s) begin
            vals_r     <= cap_r;
            idx_r      <= IDX_W'(0);
            field_en_r <= NUM_FIELDS'(0);
            busy_r     <= 1'b0;
            aborted_r  <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            case (key_s)
              KEY_STAR: begin
                idx_r      <= idx_r - IDX_W'(1);
                field_en_r <= field_en_r >> 1;
              end
              KEY_SHARP: begin
                if (idx_r == IDX_W'(NUM_FIELDS - 1)) begin
                  field_en_r <= NUM_FIELDS'(0);
                  busy_r     <= 1'b0;
                  complete_r <= 1'b1;
                  state_r    <= ST_DONE;
                end else begin
                  idx_r      <= idx_r + IDX_W'(1);
                  field_en_r <= field_en_r << 1;
                end
              end
              KEY_UP:   vals_r[int'(idx_r)*FIELD_W +: FIELD_W] <= inc_s;
              KEY_DOWN: vals_r[int'(idx_r)*FIELD_W +: FIELD_W] <= dec_s;
              default:  state_r <= ST_EDIT;
            endcase
          end
        end
        ST_DONE: begin
          idx_r   <= IDX_W'(0);
          state_r <= ST_IDLE;
        end
        default: begin
          idx_r      <= IDX_W'(0);
          field_en_r <= NUM_FIELDS'(0);
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign field_en        = field_en_r;
  assign set_vals        = vals_r;
  assign busy            = busy_r;
  assign completeSetting = complete_r;
  assign aborted         = aborted_r;

endmodule
